// File: rtl/jtframe_sdram_rr.sv
// Round-robin share of one SDRAM command port among N requesters, with periodic refresh slots.
// Latency req->sdr_req 1 cycle; one transaction in flight, controller stalls hold state.
module jtframe_sdram_rr #(
    parameter int N          = 4,
    parameter int AW         = 22,
    parameter int REF_CYCLES = 780
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N*AW-1:0] addr,
    input  logic [N*16-1:0] din,
    input  logic [N*2-1:0]  wmask,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    rdy,
    output logic [15:0]     dout,
    output logic            busy,
    output logic            sdr_req,
    output logic            sdr_we,
    output logic [AW-1:0]   sdr_addr,
    output logic [15:0]     sdr_din,
    output logic [1:0]      sdr_wmask,
    input  logic            sdr_ack,
    input  logic            sdr_rdy,
    input  logic [15:0]     sdr_dout,
    output logic            sdr_rfsh,
    input  logic            sdr_rfsh_ack,
    output logic            ref_miss
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REF_CYCLES - 1);
    localparam logic [GW-1:0] LAST_RST   = GW'(N - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, RFSH} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d, last_q, last_d;
    logic            sdr_we_q, sdr_we_d;
    logic [AW-1:0]   sdr_addr_q, sdr_addr_d;
    logic [15:0]     sdr_din_q, sdr_din_d;
    logic [1:0]      sdr_wmask_q, sdr_wmask_d;
    logic            sdr_req_q, sdr_req_d;
    logic            sdr_rfsh_q, sdr_rfsh_d;
    logic [N-1:0]    ack_q, ack_d, rdy_q, rdy_d;
    logic [15:0]     dout_q, dout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      pend_q, pend_d;
    logic            ref_miss_q, ref_miss_d;
    logic            tick, rfsh_done, found;
    logic [GW-1:0]   win, cand;

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        sdr_we_d    = sdr_we_q;
        sdr_addr_d  = sdr_addr_q;
        sdr_din_d   = sdr_din_q;
        sdr_wmask_d = sdr_wmask_q;
        sdr_req_d   = sdr_req_q;
        sdr_rfsh_d  = sdr_rfsh_q;
        ack_d       = '0;
        rdy_d       = '0;
        dout_d      = dout_q;
        pend_d      = pend_q;
        ref_miss_d  = ref_miss_q;
        rfsh_done   = 1'b0;
        tick        = (cnt_q == '0);
        cnt_d       = tick ? CNT_RELOAD : cnt_q - 1'b1;

        // Search starts just after the last served requester.
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(last_q) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_q != 2'd0) begin
                    state_d    = RFSH;
                    sdr_rfsh_d = 1'b1;
                end else if (found) begin
                    state_d     = CMD;
                    sdr_req_d   = 1'b1;
                    g_d         = win;
                    sdr_we_d    = we[win];
                    sdr_addr_d  = addr[int'(win)*AW +: AW];
                    sdr_din_d   = din[int'(win)*16 +: 16];
                    sdr_wmask_d = wmask[int'(win)*2 +: 2];
                end
            end
            CMD: begin
                if (sdr_ack) begin
                    sdr_req_d  = 1'b0;
                    ack_d[g_q] = 1'b1;
                    if (sdr_rdy) begin
                        rdy_d[g_q] = 1'b1;
                        dout_d     = sdr_dout;
                        last_d     = g_q;
                        state_d    = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (sdr_rdy) begin
                    rdy_d[g_q] = 1'b1;
                    dout_d     = sdr_dout;
                    last_d     = g_q;
                    state_d    = IDLE;
                end
            end
            RFSH: begin
                if (sdr_rfsh_ack) begin
                    sdr_rfsh_d = 1'b0;
                    rfsh_done  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry and completion in the same cycle cancel out.
        case ({tick, rfsh_done})
            2'b10: begin
                if (pend_q == 2'd3) ref_miss_d = 1'b1;
                else                pend_d     = pend_q + 2'd1;
            end
            2'b01:   pend_d = pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            last_q      <= LAST_RST;
            sdr_we_q    <= 1'b0;
            sdr_addr_q  <= '0;
            sdr_din_q   <= '0;
            sdr_wmask_q <= '0;
            sdr_req_q   <= 1'b0;
            sdr_rfsh_q  <= 1'b0;
            ack_q       <= '0;
            rdy_q       <= '0;
            dout_q      <= '0;
            cnt_q       <= CNT_RELOAD;
            pend_q      <= '0;
            ref_miss_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            sdr_we_q    <= sdr_we_d;
            sdr_addr_q  <= sdr_addr_d;
            sdr_din_q   <= sdr_din_d;
            sdr_wmask_q <= sdr_wmask_d;
            sdr_req_q   <= sdr_req_d;
            sdr_rfsh_q  <= sdr_rfsh_d;
            ack_q       <= ack_d;
            rdy_q       <= rdy_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            ref_miss_q  <= ref_miss_d;
        end
    end

    assign ack       = ack_q;
    assign rdy       = rdy_q;
    assign dout      = dout_q;
    assign busy      = (state_q != IDLE);
    assign sdr_req   = sdr_req_q;
    assign sdr_we    = sdr_we_q;
    assign sdr_addr  = sdr_addr_q;
    assign sdr_din   = sdr_din_q;
    assign sdr_wmask = sdr_wmask_q;
    assign sdr_rfsh  = sdr_rfsh_q;
    assign ref_miss  = ref_miss_q;

endmodule

// File: tb/tb_jtframe_sdram_rr.sv
// Directed bench: u_a uses the default refresh period, u_b a 20-cycle period; inputs are shared.
module tb_jtframe_sdram_rr;
    localparam int N  = 4;
    localparam int AW = 22;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*16-1:0] din;
    logic [N*2-1:0]  wmask;
    logic            sdr_ack, sdr_rdy, sdr_rfsh_ack;
    logic [15:0]     sdr_dout;

    logic [N-1:0]  a_ack, a_rdy, b_ack, b_rdy;
    logic [15:0]   a_dout, b_dout, a_sdr_din, b_sdr_din;
    logic          a_busy, b_busy, a_sdr_req, b_sdr_req, a_sdr_we, b_sdr_we;
    logic [AW-1:0] a_sdr_addr, b_sdr_addr;
    logic [1:0]    a_sdr_wmask, b_sdr_wmask;
    logic          a_sdr_rfsh, b_sdr_rfsh, a_ref_miss, b_ref_miss;

    logic [AW-1:0] lane_addr [N];
    int checks = 0;
    int errors = 0;

    jtframe_sdram_rr #(.N(N), .AW(AW), .REF_CYCLES(780)) u_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din), .wmask(wmask),
        .ack(a_ack), .rdy(a_rdy), .dout(a_dout), .busy(a_busy),
        .sdr_req(a_sdr_req), .sdr_we(a_sdr_we), .sdr_addr(a_sdr_addr), .sdr_din(a_sdr_din),
        .sdr_wmask(a_sdr_wmask), .sdr_ack(sdr_ack), .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout),
        .sdr_rfsh(a_sdr_rfsh), .sdr_rfsh_ack(sdr_rfsh_ack), .ref_miss(a_ref_miss)
    );

    jtframe_sdram_rr #(.N(N), .AW(AW), .REF_CYCLES(20)) u_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din), .wmask(wmask),
        .ack(b_ack), .rdy(b_rdy), .dout(b_dout), .busy(b_busy),
        .sdr_req(b_sdr_req), .sdr_we(b_sdr_we), .sdr_addr(b_sdr_addr), .sdr_din(b_sdr_din),
        .sdr_wmask(b_sdr_wmask), .sdr_ack(sdr_ack), .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout),
        .sdr_rfsh(b_sdr_rfsh), .sdr_rfsh_ack(sdr_rfsh_ack), .ref_miss(b_ref_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the caller at the negedge where rst drops; the next posedge is the first live cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0; we = '0;
        sdr_ack = 1'b0; sdr_rdy = 1'b0; sdr_rfsh_ack = 1'b0; sdr_dout = '0;
        lane_addr[0] = 22'h000123; lane_addr[1] = 22'h3F0011;
        lane_addr[2] = 22'h2A5555; lane_addr[3] = 22'h100003;
        addr  = {lane_addr[3], lane_addr[2], lane_addr[1], lane_addr[0]};
        din   = {16'h4444, 16'h3333, 16'h5A5A, 16'h1111};
        wmask = {2'b11, 2'b01, 2'b10, 2'b00};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_ack, a_rdy, a_dout, a_busy, a_sdr_req, a_sdr_we, a_sdr_addr, a_sdr_din,
             a_sdr_wmask, a_sdr_rfsh, a_ref_miss} !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs not all zero (ack=%b rdy=%b dout=%h busy=%b req=%b)",
                     a_ack, a_rdy, a_dout, a_busy, a_sdr_req);
        end
        checks++;
        if ({b_ack, b_rdy, b_dout, b_busy, b_sdr_req, b_sdr_we, b_sdr_addr, b_sdr_din,
             b_sdr_wmask, b_sdr_rfsh, b_ref_miss} !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs not all zero (ack=%b rdy=%b dout=%h busy=%b req=%b)",
                     b_ack, b_rdy, b_dout, b_busy, b_sdr_req);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if ({a_sdr_req, a_busy, a_sdr_we, a_sdr_addr} !== {1'b1, 1'b1, 1'b0, 22'h000123}) begin
            errors++;
            $display("FAIL read_grant: got req=%b busy=%b we=%b addr=%h expected 1 1 0 000123",
                     a_sdr_req, a_busy, a_sdr_we, a_sdr_addr);
        end
        @(negedge clk);
        checks++;
        if ({a_sdr_req, a_ack} !== {1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL read_hold: got req=%b ack=%b expected 1 0000", a_sdr_req, a_ack);
        end
        sdr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ack, a_sdr_req, a_busy} !== {4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL read_ack: got ack=%b req=%b busy=%b expected 0001 0 1",
                     a_ack, a_sdr_req, a_busy);
        end
        sdr_ack = 1'b0;
        req = '0;
        @(negedge clk);
        checks++;
        if (a_ack !== 4'b0000) begin
            errors++;
            $display("FAIL read_ack_pulse: got %b expected 0000", a_ack);
        end
        @(negedge clk);
        sdr_rdy = 1'b1;
        sdr_dout = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({a_rdy, a_dout} !== {4'b0001, 16'hBEEF}) begin
            errors++;
            $display("FAIL read_rdy: got rdy=%b dout=%h expected 0001 beef", a_rdy, a_dout);
        end
        sdr_rdy = 1'b0;
        sdr_dout = '0;
        @(negedge clk);
        checks++;
        if ({a_rdy, a_dout, a_busy} !== {4'b0000, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL read_after: got rdy=%b dout=%h busy=%b expected 0000 beef 0",
                     a_rdy, a_dout, a_busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (t % 4);
            @(negedge clk);
            checks++;
            if ({a_sdr_req, a_sdr_addr} !== {1'b1, lane_addr[t % 4]}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got req=%b addr=%h expected 1 %h",
                         t, a_sdr_req, a_sdr_addr, lane_addr[t % 4]);
            end
            sdr_ack = 1'b1;
            @(negedge clk);
            checks++;
            if ({a_ack, a_rdy, a_sdr_req} !== {oh, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL rr_ack[%0d]: got ack=%b rdy=%b req=%b expected %b 0000 0",
                         t, a_ack, a_rdy, a_sdr_req, oh);
            end
            sdr_ack = 1'b0;
            sdr_rdy = 1'b1;
            sdr_dout = 16'h1000 + 16'(t);
            @(negedge clk);
            checks++;
            if ({a_rdy, a_ack, a_dout} !== {oh, 4'b0000, 16'h1000 + 16'(t)}) begin
                errors++;
                $display("FAIL rr_rdy[%0d]: got rdy=%b ack=%b dout=%h expected %b 0000 %h",
                         t, a_rdy, a_ack, a_dout, oh, 16'h1000 + 16'(t));
            end
            checks++;
            if ($countones(a_ack) > 1 || $countones(a_rdy) > 1) begin
                errors++;
                $display("FAIL rr_onehot[%0d]: got ack=%b rdy=%b expected at most one bit each",
                         t, a_ack, a_rdy);
            end
            sdr_rdy = 1'b0;
        end
        req = '0;
    endtask

    task automatic test_write();
        do_reset();
        req = 4'b0010;
        we  = 4'b0010;
        @(negedge clk);
        checks++;
        if ({a_sdr_req, a_sdr_we, a_sdr_din, a_sdr_wmask, a_sdr_addr} !==
            {1'b1, 1'b1, 16'h5A5A, 2'b10, lane_addr[1]}) begin
            errors++;
            $display("FAIL wr_grant: got req=%b we=%b din=%h mask=%b addr=%h expected 1 1 5a5a 10 %h",
                     a_sdr_req, a_sdr_we, a_sdr_din, a_sdr_wmask, a_sdr_addr, lane_addr[1]);
        end
        req = '0; we = '0; din = '0; wmask = '1;
        @(negedge clk);
        checks++;
        if ({a_sdr_req, a_sdr_we, a_sdr_din, a_sdr_wmask} !== {1'b1, 1'b1, 16'h5A5A, 2'b10}) begin
            errors++;
            $display("FAIL wr_hold: got req=%b we=%b din=%h mask=%b expected 1 1 5a5a 10",
                     a_sdr_req, a_sdr_we, a_sdr_din, a_sdr_wmask);
        end
        sdr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ack, a_sdr_we, a_sdr_din} !== {4'b0010, 1'b1, 16'h5A5A}) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b we=%b din=%h expected 0010 1 5a5a",
                     a_ack, a_sdr_we, a_sdr_din);
        end
        sdr_ack = 1'b0;
        sdr_rdy = 1'b1;
        sdr_dout = 16'h0F0F;
        @(negedge clk);
        checks++;
        if ({a_rdy, a_dout, a_busy} !== {4'b0010, 16'h0F0F, 1'b0}) begin
            errors++;
            $display("FAIL wr_rdy: got rdy=%b dout=%h busy=%b expected 0010 0f0f 0",
                     a_rdy, a_dout, a_busy);
        end
        sdr_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (a_sdr_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_regrant: got sdr_req=%b expected 0", a_sdr_req);
        end
    endtask

    // First expiry is 20 live cycles after reset; each refresh is visible one cycle later.
    task automatic test_refresh_period();
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            logic exp_rf;
            @(negedge clk);
            sdr_rfsh_ack = 1'b0;
            exp_rf = (k >= 21) && (k % 20 >= 1) && (k % 20 <= 3);
            checks++;
            if ({b_sdr_rfsh, b_busy, b_ref_miss, b_sdr_req} !== {exp_rf, exp_rf, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rfsh_cycle[%0d]: got rfsh=%b busy=%b miss=%b req=%b expected %b %b 0 0",
                         k, b_sdr_rfsh, b_busy, b_ref_miss, b_sdr_req, exp_rf, exp_rf);
            end
            if (k >= 23 && k % 20 == 3) sdr_rfsh_ack = 1'b1;
        end
        sdr_rfsh_ack = 1'b0;
    endtask

    // Leaves u_b in CMD for requester 1, used by test_reset_in_data.
    task automatic test_refresh_backlog();
        do_reset();
        req = 4'b0100;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 2) req = '0;
            if (k == 79) begin
                checks++;
                if (b_ref_miss !== 1'b0) begin
                    errors++;
                    $display("FAIL miss_early: got ref_miss=%b expected 0", b_ref_miss);
                end
            end
            if (k == 80) begin
                checks++;
                if (b_ref_miss !== 1'b1) begin
                    errors++;
                    $display("FAIL miss_set: got ref_miss=%b expected 1", b_ref_miss);
                end
            end
            if (k == 99) begin
                checks++;
                if ({b_sdr_req, b_busy, b_sdr_rfsh, b_sdr_addr} !== {1'b1, 1'b1, 1'b0, lane_addr[2]}) begin
                    errors++;
                    $display("FAIL stall_hold: got req=%b busy=%b rfsh=%b addr=%h expected 1 1 0 %h",
                             b_sdr_req, b_busy, b_sdr_rfsh, b_sdr_addr, lane_addr[2]);
                end
            end
        end
        sdr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ack !== 4'b0100) begin
            errors++;
            $display("FAIL stall_ack: got ack=%b expected 0100", b_ack);
        end
        sdr_ack = 1'b0;
        sdr_rdy = 1'b1;
        sdr_dout = 16'hC0DE;
        @(negedge clk);
        checks++;
        if ({b_rdy, b_dout} !== {4'b0100, 16'hC0DE}) begin
            errors++;
            $display("FAIL stall_rdy: got rdy=%b dout=%h expected 0100 c0de", b_rdy, b_dout);
        end
        sdr_rdy = 1'b0;
        req = 4'b0010;
        for (int k = 103; k <= 109; k++) begin
            logic exp_rf;
            @(negedge clk);
            sdr_rfsh_ack = 1'b0;
            exp_rf = (k == 103) || (k == 105) || (k == 107);
            checks++;
            if ({b_sdr_rfsh, b_sdr_req} !== {exp_rf, k == 109}) begin
                errors++;
                $display("FAIL backlog[%0d]: got rfsh=%b req=%b expected %b %b",
                         k, b_sdr_rfsh, b_sdr_req, exp_rf, k == 109);
            end
            if (exp_rf) sdr_rfsh_ack = 1'b1;
        end
        checks++;
        if ({b_sdr_addr, b_ref_miss} !== {lane_addr[1], 1'b1}) begin
            errors++;
            $display("FAIL backlog_grant: got addr=%h miss=%b expected %h 1",
                     b_sdr_addr, b_ref_miss, lane_addr[1]);
        end
    endtask

    task automatic test_reset_in_data();
        req = '0;
        sdr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_ack, b_busy, b_ref_miss} !== {4'b0010, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL pre_rst: got ack=%b busy=%b miss=%b expected 0010 1 1",
                     b_ack, b_busy, b_ref_miss);
        end
        sdr_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_ack, b_rdy, b_dout, b_busy, b_sdr_req, b_sdr_we, b_sdr_addr, b_sdr_din,
             b_sdr_wmask, b_sdr_rfsh, b_ref_miss} !== '0) begin
            errors++;
            $display("FAIL rst_data: outputs not zero (dout=%h busy=%b addr=%h miss=%b)",
                     b_dout, b_busy, b_sdr_addr, b_ref_miss);
        end
        rst = 1'b0;
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if ({b_sdr_req, b_sdr_addr} !== {1'b1, lane_addr[3]}) begin
            errors++;
            $display("FAIL rst_regrant: got req=%b addr=%h expected 1 %h",
                     b_sdr_req, b_sdr_addr, lane_addr[3]);
        end
        sdr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ack !== 4'b1000) begin
            errors++;
            $display("FAIL rst_ack: got ack=%b expected 1000", b_ack);
        end
        sdr_ack = 1'b0;
        sdr_rdy = 1'b1;
        sdr_dout = 16'h7777;
        req = '0;
        @(negedge clk);
        checks++;
        if ({b_rdy, b_dout, b_ref_miss} !== {4'b1000, 16'h7777, 1'b0}) begin
            errors++;
            $display("FAIL rst_rdy: got rdy=%b dout=%h miss=%b expected 1000 7777 0",
                     b_rdy, b_dout, b_ref_miss);
        end
        sdr_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_refresh_period();
        test_refresh_backlog();
        test_reset_in_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
